// File: rtl/fuzzy_t2_defuzz_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fuzzy_t2_pkg
// Brief    : Shared constants and width helpers for the type-2 defuzzifier
// Revision : 1.0
// ============================================================================
package fuzzy_t2_pkg;

   localparam logic [1:0] MODE_NT  = 2'd0;
   localparam logic [1:0] MODE_UP  = 2'd1;
   localparam logic [1:0] MODE_LOW = 2'd2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_DIV   = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   function automatic int f_w_w(input int dw);
      return dw + 1;
   endfunction

   function automatic int f_num_w(input int dw, input int ridx_w);
      return f_w_w(dw) + dw + ridx_w;
   endfunction

   function automatic int f_den_w(input int dw, input int ridx_w);
      return f_w_w(dw) + ridx_w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fuzzy_t2_defuzz_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Brief    : Restoring divider, one quotient bit per cycle, MSB first
// Revision : 1.0
// ============================================================================
module seq_divider #(
   parameter int NUM_W = 21,
   parameter int DEN_W = 13,
   parameter int Q_W   = 8
) (
   input  logic             clk_0,
   input  logic             rst,
   input  logic             i_start,
   input  logic [NUM_W-1:0] i_num,
   input  logic [DEN_W-1:0] i_den,
   output logic             o_done,
   output logic [Q_W-1:0]   o_q
);

   localparam int SW = (NUM_W > DEN_W + Q_W) ? NUM_W : DEN_W + Q_W;
   localparam int CW = (Q_W > 1) ? $clog2(Q_W) : 1;

   logic [SW-1:0]  r_rem;
   logic [SW-1:0]  r_div;
   logic [CW-1:0]  r_cnt;
   logic           r_busy;
   logic [Q_W-1:0] r_q;
   logic           w_ge;
   logic [SW-1:0]  w_diff;

   assign w_ge   = (r_rem >= r_div);
   assign w_diff = r_rem - r_div;

   // High during the step that writes the last quotient bit; o_q is final afterwards.
   assign o_done = r_busy && (r_cnt == '0);
   assign o_q    = r_q;

   always_ff @(posedge clk_0 or posedge rst) begin
      if (rst) begin
         r_rem  <= '0;
         r_div  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_q    <= '0;
      end else if (i_start) begin
         r_rem  <= SW'(i_num);
         r_div  <= SW'(i_den) << (Q_W - 1);
         r_cnt  <= CW'(Q_W - 1);
         r_busy <= 1'b1;
         r_q    <= '0;
      end else if (r_busy) begin
         if (w_ge) begin
            r_rem <= w_diff;
         end
         r_q   <= (r_q << 1) | Q_W'(w_ge);
         r_div <= r_div >> 1;
         r_cnt <= r_cnt - CW'(1);
         if (r_cnt == '0) begin
            r_busy <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/fuzzy_t2_defuzz_seq.sv
`default_nettype none
// ============================================================================
// Module   : fuzzy_t2_defuzz_seq
// Brief    : Sequential interval type-2 defuzzifier (weighted centroid + divide)
// Revision : 1.0
// ============================================================================
module fuzzy_t2_defuzz_seq
   import fuzzy_t2_pkg::*;
#(
   parameter int            DW          = 8,
   parameter int            N_RULES     = 9,
   parameter int            RIDX_W      = (N_RULES > 1) ? $clog2(N_RULES) : 1,
   parameter logic [DW-1:0] DEFAULT_OUT = DW'(128),
   // Derived widths, not meant to be overridden.
   parameter int            W_W         = f_w_w(DW),
   parameter int            NUM_W       = f_num_w(DW, RIDX_W),
   parameter int            DEN_W       = f_den_w(DW, RIDX_W)
) (
   input  logic              clk_0,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        mode,
   output logic [RIDX_W-1:0] rule_idx,
   input  logic [DW-1:0]     fs_up,
   input  logic [DW-1:0]     fs_low,
   input  logic [DW-1:0]     centroid,
   output logic              busy,
   output logic              done,
   output logic [DW-1:0]     y,
   output logic              no_fire,
   output logic [NUM_W-1:0]  sum_num,
   output logic [DEN_W-1:0]  sum_den
);

   logic [1:0]        r_state;
   logic [1:0]        w_next;
   logic [1:0]        r_mode;
   logic [RIDX_W-1:0] r_rule_idx;
   logic              r_busy;
   logic              r_done;
   logic [DW-1:0]     r_y;
   logic              r_no_fire;
   logic [NUM_W-1:0]  r_sum_num;
   logic [DEN_W-1:0]  r_sum_den;

   logic [W_W-1:0]    w_w;
   logic [NUM_W-1:0]  w_num_nxt;
   logic [DEN_W-1:0]  w_den_nxt;
   logic              w_last;
   logic              w_accept;
   logic              w_acc_en;
   logic              w_div_start;
   logic              w_finish;
   logic              w_div_done;
   logic [DW-1:0]     w_q;

   // Nie-Tan weight is left unhalved: the factor of two cancels in the ratio.
   always_comb begin
      case (r_mode)
         MODE_UP:  w_w = {1'b0, fs_up};
         MODE_LOW: w_w = {1'b0, fs_low};
         default:  w_w = W_W'(fs_up) + W_W'(fs_low);
      endcase
   end

   assign w_num_nxt = r_sum_num + (NUM_W'(w_w) * NUM_W'(centroid));
   assign w_den_nxt = r_sum_den + DEN_W'(w_w);
   assign w_last    = (r_rule_idx == RIDX_W'(N_RULES - 1));

   always_ff @(posedge clk_0 or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_next = ST_ACCUM;
         ST_ACCUM: if (w_last) w_next = (w_den_nxt == '0) ? ST_DONE : ST_DIV;
         ST_DIV:   if (w_div_done) w_next = ST_DONE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_accept    = 1'b0;
      w_acc_en    = 1'b0;
      w_div_start = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         ST_IDLE:  w_accept = start;
         ST_ACCUM: begin
            w_acc_en    = 1'b1;
            w_div_start = w_last && (w_den_nxt != '0);
         end
         ST_DONE:  w_finish = 1'b1;
         default:  ;
      endcase
   end

   // Divider is loaded with the sums including the final rule term.
   seq_divider #(
      .NUM_W (NUM_W),
      .DEN_W (DEN_W),
      .Q_W   (DW)
   ) u_div (
      .clk_0   (clk_0),
      .rst     (rst),
      .i_start (w_div_start),
      .i_num   (w_num_nxt),
      .i_den   (w_den_nxt),
      .o_done  (w_div_done),
      .o_q     (w_q)
   );

   always_ff @(posedge clk_0 or posedge rst) begin
      if (rst) begin
         r_mode     <= MODE_NT;
         r_rule_idx <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_y        <= '0;
         r_no_fire  <= 1'b0;
         r_sum_num  <= '0;
         r_sum_den  <= '0;
      end else begin
         r_done <= w_finish;
         if (w_accept) begin
            r_sum_num  <= '0;
            r_sum_den  <= '0;
            r_mode     <= mode;
            r_rule_idx <= '0;
            r_busy     <= 1'b1;
         end
         if (w_acc_en) begin
            r_sum_num  <= w_num_nxt;
            r_sum_den  <= w_den_nxt;
            r_rule_idx <= w_last ? '0 : r_rule_idx + RIDX_W'(1);
         end
         if (w_finish) begin
            r_busy    <= 1'b0;
            r_no_fire <= (r_sum_den == '0);
            r_y       <= (r_sum_den == '0) ? DEFAULT_OUT : w_q;
         end
      end
   end

   assign rule_idx = r_rule_idx;
   assign busy     = r_busy;
   assign done     = r_done;
   assign y        = r_y;
   assign no_fire  = r_no_fire;
   assign sum_num  = r_sum_num;
   assign sum_den  = r_sum_den;

endmodule
`default_nettype wire

// File: tb/tb_fuzzy_t2_defuzz_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fuzzy_t2_defuzz_seq
// Brief    : Vector table + scoreboard bench for the type-2 defuzzifier
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_fuzzy_t2_defuzz_seq;

   localparam int DW = 8;
   localparam int NR = 9;
   localparam int RW = 4;
   localparam int NUM_W = 21;
   localparam int DEN_W = 13;
   localparam int NV = 10;

   logic             clk_0 = 1'b0;
   logic             rst;
   logic             start;
   logic [1:0]       mode;
   logic [RW-1:0]    rule_idx;
   logic [DW-1:0]    fs_up, fs_low, centroid;
   logic             busy, done, no_fire;
   logic [DW-1:0]    y;
   logic [NUM_W-1:0] sum_num;
   logic [DEN_W-1:0] sum_den;

   always #5 clk_0 = ~clk_0;

   fuzzy_t2_defuzz_seq dut (
      .clk_0    (clk_0),
      .rst      (rst),
      .start    (start),
      .mode     (mode),
      .rule_idx (rule_idx),
      .fs_up    (fs_up),
      .fs_low   (fs_low),
      .centroid (centroid),
      .busy     (busy),
      .done     (done),
      .y        (y),
      .no_fire  (no_fire),
      .sum_num  (sum_num),
      .sum_den  (sum_den)
   );

   typedef struct {
      logic [NR-1:0][DW-1:0] up;
      logic [NR-1:0][DW-1:0] low;
      logic [NR-1:0][DW-1:0] cen;
      logic [1:0]            md;
      logic [DW-1:0]         ey;
      logic                  enf;
      int                    enum_v;
      int                    eden;
   } vec_t;

   typedef struct {
      logic [DW-1:0] y;
      logic          nf;
      int            num;
      int            den;
      int            t0;
      int            lat;
   } exp_t;

   vec_t vt[NV];
   exp_t sb[$];
   exp_t e;

   logic [NR-1:0][DW-1:0] a_up, a_low, a_cen;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   n_done = 0;
   logic prev_done = 1'b0;

   always @(posedge clk_0) cyc <= cyc + 1;

   // Upstream rule memory model: answers the slot addressed by rule_idx.
   always_comb begin
      fs_up    = '0;
      fs_low   = '0;
      centroid = '0;
      if (rule_idx < RW'(NR)) begin
         fs_up    = a_up[rule_idx];
         fs_low   = a_low[rule_idx];
         centroid = a_cen[rule_idx];
      end
   end

   task automatic chk(input string nm, input longint act, input longint req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic push_exp(input int yv, input int nf, input int num, input int den,
                           input int t0);
      exp_t x;
      x.y   = DW'(yv);
      x.nf  = nf[0];
      x.num = num;
      x.den = den;
      x.t0  = t0;
      x.lat = (nf != 0) ? NR + 1 : NR + DW + 1;
      sb.push_back(x);
   endtask

   always @(negedge clk_0) begin
      if (rst) begin
         prev_done = 1'b0;
      end else begin
         if (done) begin
            chk("done_one_cycle", prev_done, 0);
            chk("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("y", y, e.y);
               chk("no_fire", no_fire, e.nf);
               chk("sum_num", sum_num, e.num);
               chk("sum_den", sum_den, e.den);
               chk("latency", cyc - e.t0, e.lat);
               chk("busy_at_done", busy, 0);
            end
            n_done++;
         end
         prev_done = done;
      end
   end

   task automatic wait_done(input int target);
      for (int k = 0; k < 80 && n_done < target; k++) @(posedge clk_0);
      chk("done_arrived", n_done >= target, 1);
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) begin
         @(posedge clk_0);
         #1;
      end
   endtask

   task automatic load_vec(input int i);
      a_up  = vt[i].up;
      a_low = vt[i].low;
      a_cen = vt[i].cen;
      mode  = vt[i].md;
   endtask

   task automatic run_vec(input int i);
      int base;
      base = n_done;
      load_vec(i);
      @(negedge clk_0);
      start = 1'b1;
      @(posedge clk_0);
      #1;
      start = 1'b0;
      push_exp(vt[i].ey, vt[i].enf, vt[i].enum_v, vt[i].eden, cyc);
      wait_done(base + 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t0;
      int base;
      for (int i = 0; i < NV; i++) begin
         vt[i].up = '0; vt[i].low = '0; vt[i].cen = '0; vt[i].md = 2'd0;
      end
      // 0: nothing fires
      vt[0].ey = 8'd128; vt[0].enf = 1'b1; vt[0].enum_v = 0; vt[0].eden = 0;
      // 1: rule 4 only
      vt[1].up[4] = 8'd200; vt[1].low[4] = 8'd100; vt[1].cen[4] = 8'd128;
      vt[1].ey = 8'd128; vt[1].enf = 1'b0; vt[1].enum_v = 38400; vt[1].eden = 300;
      // 2..5: upper rule at c=0, lower rule at c=240, all modes
      for (int i = 2; i <= 5; i++) begin
         vt[i].up[0] = 8'd100; vt[i].cen[0] = 8'd0;
         vt[i].low[1] = 8'd100; vt[i].cen[1] = 8'd240;
         vt[i].enf = 1'b0;
      end
      vt[2].md = 2'd1; vt[2].ey = 8'd0;   vt[2].enum_v = 0;     vt[2].eden = 100;
      vt[3].md = 2'd2; vt[3].ey = 8'd240; vt[3].enum_v = 24000; vt[3].eden = 100;
      vt[4].md = 2'd0; vt[4].ey = 8'd120; vt[4].enum_v = 24000; vt[4].eden = 200;
      vt[5].md = 2'd3; vt[5].ey = 8'd120; vt[5].enum_v = 24000; vt[5].eden = 200;
      // 6: first and last slots saturated
      vt[6].up[0] = 8'd255; vt[6].low[0] = 8'd255; vt[6].cen[0] = 8'd32;
      vt[6].up[8] = 8'd255; vt[6].low[8] = 8'd255; vt[6].cen[8] = 8'd224;
      vt[6].ey = 8'd128; vt[6].enf = 1'b0; vt[6].enum_v = 130560; vt[6].eden = 1020;
      // 7: every input at full scale
      for (int r = 0; r < NR; r++) begin
         vt[7].up[r] = 8'd255; vt[7].low[r] = 8'd255; vt[7].cen[r] = 8'd255;
      end
      vt[7].ey = 8'd255; vt[7].enf = 1'b0; vt[7].enum_v = 1170450; vt[7].eden = 4590;
      // 8: truncating quotient 110/7, lower strengths ignored in mode 1
      vt[8].md = 2'd1;
      vt[8].up[0] = 8'd3; vt[8].low[0] = 8'd50; vt[8].cen[0] = 8'd10;
      vt[8].up[1] = 8'd4; vt[8].low[1] = 8'd60; vt[8].cen[1] = 8'd20;
      vt[8].ey = 8'd15; vt[8].enf = 1'b0; vt[8].enum_v = 110; vt[8].eden = 7;
      // 9: only upper fires but mode 2 selects lower -> no fire
      vt[9].md = 2'd2; vt[9].up[2] = 8'd255; vt[9].cen[2] = 8'd77;
      vt[9].ey = 8'd128; vt[9].enf = 1'b1; vt[9].enum_v = 0; vt[9].eden = 0;

      rst = 1'b1; start = 1'b0; mode = 2'd0;
      a_up = '0; a_low = '0; a_cen = '0;
      repeat (3) @(posedge clk_0);
      @(negedge clk_0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_y", y, 0);
      chk("rst_no_fire", no_fire, 0);
      chk("rst_rule_idx", rule_idx, 0);
      chk("rst_sum_num", sum_num, 0);
      chk("rst_sum_den", sum_den, 0);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) run_vec(i);

      // Reset in the middle of accumulation
      load_vec(1);
      @(negedge clk_0);
      start = 1'b1;
      @(posedge clk_0);
      #1;
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      for (int k = 0; k < 20 && rule_idx != RW'(5); k++) begin
         @(posedge clk_0);
         #1;
      end
      chk("reach_idx5", rule_idx, 5);
      @(negedge clk_0);
      rst = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_y", y, 0);
      chk("midrst_rule_idx", rule_idx, 0);
      chk("midrst_sum_num", sum_num, 0);
      chk("midrst_sum_den", sum_den, 0);
      chk("midrst_done", done, 0);
      @(negedge clk_0);
      rst = 1'b0;
      base = n_done;
      repeat (25) @(posedge clk_0);
      chk("no_done_after_rst", n_done, base);
      run_vec(1);

      // start held high: acceptance only in IDLE, mode latched per evaluation
      base = n_done;
      load_vec(4);
      @(negedge clk_0);
      start = 1'b1;
      @(posedge clk_0);
      #1;
      t0 = cyc;
      push_exp(120, 0, 24000, 200, t0);
      push_exp(0, 0, 0, 100, t0 + NR + DW + 2);
      push_exp(240, 0, 24000, 100, t0 + 2 * (NR + DW + 2));
      wait_cyc(t0 + 2);
      mode = 2'd1;
      wait_cyc(t0 + NR + DW + 4);
      mode = 2'd2;
      wait_cyc(t0 + 2 * (NR + DW + 2) + 2);
      start = 1'b0;
      wait_done(base + 3);
      repeat (25) @(posedge clk_0);
      chk("sb_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
